// File: rtl/serial_paralelo_param_pkg.sv
// Shared types and helpers for the parametrised serial-to-parallel receiver.
//   state_t      : lock state (SEARCH / ALIGN / ACTIVE)
//   COM_W8/IDL_W8: default comma and idle symbols for 8-bit symbols
//   cnt_width()  : bits needed to hold a counter value 0..max_val
package sp_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] COM_W8 = 8'hBC;
  localparam logic [7:0] IDL_W8 = 8'h7C;

  // Width of a counter that must hold values 0..max_val (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_paralelo_param_if.sv
// Serial-in / word-out bus of the receiver.
//   data_in     : serial bit, MSB first
//   data_out    : last aligned word received while locked
//   valid_out   : data_out is neither COM nor IDL
//   active      : lock achieved
//   word_strobe : one-cycle pulse per aligned word while locked
// master drives data_in (the line side); slave is the receiver.
interface serial_paralelo_param_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;
  logic             word_strobe;

  modport master (
    output data_in,
    input  data_out, valid_out, active, word_strobe
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, active, word_strobe
  );

endinterface

// File: rtl/serial_paralelo_param_lock_fsm.sv
// Lock state machine of the receiver.
//   clk, rst_n    : bit clock, async active-low reset
//   boundary      : this edge samples the last bit of an aligned word
//   is_com/is_idl : the word ending on this edge is COM / IDL
//   lock_hit      : this aligned COM is the LOCK_COUNT-th in a row
//   gap_at_limit  : one more non-COM/IDL word reaches the gap limit
//   state, active : registered lock state and lock flag
//   gap_timeout_c : combinational, lock is dropped on this edge
module sp_lock_fsm
  import sp_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   boundary,
  input  logic   is_com,
  input  logic   is_idl,
  input  logic   lock_hit,
  input  logic   gap_at_limit,
  output state_t state,
  output logic   active,
  output logic   gap_timeout_c
);

  assign gap_timeout_c = (state == ACTIVE) && boundary && !is_com && !is_idl && gap_at_limit;

  // SEARCH slides over every edge; ALIGN/ACTIVE only look at word boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      active <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (is_com) begin
            if (LOCK_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (!is_com) begin
              state <= SEARCH;
            end else if (lock_hit) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (gap_timeout_c) begin
            state  <= SEARCH;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_paralelo_param.sv
// Parametrised serial-to-parallel receiver with COM alignment and lock.
//   clk_32f : serial bit clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : slave side of serial_paralelo_param_if
//             (data_in in; data_out, valid_out, active, word_strobe out)
// Shifts MSB first, locks after LOCK_COUNT aligned COMs, then emits one
// word per WIDTH clocks. GAP_LIMIT>0 drops lock after that many aligned
// words without COM/IDL.
module serial_paralelo_param
  import sp_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_W8),
  parameter logic [WIDTH-1:0] IDL        = WIDTH'(IDL_W8),
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      GAP_LIMIT  = 0
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  serial_paralelo_param_if.slave bus
);

  localparam int unsigned BIT_W = cnt_width(WIDTH - 1);
  localparam int unsigned COM_W = cnt_width(LOCK_COUNT);
  localparam int unsigned GAP_W = cnt_width(GAP_LIMIT);

  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nxt_c;
  logic [BIT_W-1:0] bit_cnt;
  logic [COM_W-1:0] com_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             is_com_c, is_idl_c, boundary_c, lock_hit_c, gap_at_limit_c;
  logic             gap_timeout_c;
  state_t           state;
  logic             lock_active;

  logic [WIDTH-1:0] data_out_q;
  logic             valid_q, strobe_q;

  // Word ending on this edge: decisions see the bit being sampled now.
  assign nxt_c          = {sr, bus.data_in};
  assign is_com_c       = (nxt_c == COM);
  assign is_idl_c       = (nxt_c == IDL);
  assign boundary_c     = (bit_cnt == BIT_W'(WIDTH - 1));
  assign lock_hit_c     = (com_cnt == COM_W'(LOCK_COUNT - 1));
  assign gap_at_limit_c = (GAP_LIMIT != 0) && (gap_cnt == GAP_W'(GAP_LIMIT - 1));

  sp_lock_fsm #(
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock_fsm (
    .clk           (clk_32f),
    .rst_n         (reset),
    .boundary      (boundary_c),
    .is_com        (is_com_c),
    .is_idl        (is_idl_c),
    .lock_hit      (lock_hit_c),
    .gap_at_limit  (gap_at_limit_c),
    .state         (state),
    .active        (lock_active),
    .gap_timeout_c (gap_timeout_c)
  );

  // Shift register and bit/COM/gap counters.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      bit_cnt <= '0;
      com_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      sr <= nxt_c[WIDTH-2:0];

      // A COM found while searching defines the new word phase.
      if ((state == SEARCH && is_com_c) || boundary_c) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (state == SEARCH) begin
        com_cnt <= is_com_c ? COM_W'(1) : '0;
      end else if (state == ALIGN && boundary_c) begin
        com_cnt <= is_com_c ? com_cnt + COM_W'(1) : '0;
      end

      if (state != ACTIVE) begin
        gap_cnt <= '0;
      end else if (boundary_c) begin
        if (is_com_c || is_idl_c || gap_timeout_c) begin
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
      end
    end
  end

  // Word outputs; a timeout boundary clears valid but keeps the old word.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (state == ACTIVE && boundary_c) begin
        if (gap_timeout_c) begin
          valid_q <= 1'b0;
        end else begin
          data_out_q <= nxt_c;
          strobe_q   <= 1'b1;
          valid_q    <= !is_com_c && !is_idl_c;
        end
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_q;
  assign bus.active      = lock_active;
  assign bus.word_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: two instances (no gap timeout, and
// GAP_LIMIT=3) share the serial stream and are followed edge by edge by a
// word-phase reference model, plus directed scenario checks.
module tb_serial_paralelo_param;

  localparam int unsigned W     = 8;
  localparam logic [7:0]  COM_V = 8'hBC;
  localparam logic [7:0]  IDL_V = 8'h7C;
  localparam int          LC    = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_param_if #(.WIDTH(W)) bus0 ();
  serial_paralelo_param_if #(.WIDTH(W)) bus1 ();

  serial_paralelo_param #(
    .WIDTH(W), .COM(COM_V), .IDL(IDL_V), .LOCK_COUNT(LC), .GAP_LIMIT(0)
  ) dut0 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus0.slave)
  );

  serial_paralelo_param #(
    .WIDTH(W), .COM(COM_V), .IDL(IDL_V), .LOCK_COUNT(LC), .GAP_LIMIT(3)
  ) dut1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus1.slave)
  );

  // {active, valid_out, word_strobe, data_out}
  logic [10:0] obs0, obs1;
  assign obs0 = {bus0.active, bus0.valid_out, bus0.word_strobe, bus0.data_out};
  assign obs1 = {bus1.active, bus1.valid_out, bus1.word_strobe, bus1.data_out};

  int tests  = 0;
  int failed = 0;

  // Reference model: phase of a word is (edge - align_edge) mod W.
  int          glim[2] = '{0, 3};
  int          t;
  logic [7:0]  m_win;
  int          m_st[2];      // 0 search, 1 align, 2 locked
  int          m_align[2];
  int          m_coms[2];
  int          m_gap[2];
  logic [7:0]  m_dout[2];
  bit          m_valid[2];
  bit          m_strobe[2];

  int          lockstep_err = 0;
  string       first_msg = "";

  function automatic void model_reset();
    t     = 0;
    m_win = '0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_align[i] = 0; m_coms[i] = 0; m_gap[i] = 0;
      m_dout[i] = '0; m_valid[i] = 0; m_strobe[i] = 0;
    end
  endfunction

  function automatic void model_edge(input bit b);
    bit is_com, is_idl, bnd;
    t++;
    m_win  = {m_win[6:0], b};
    is_com = (m_win == COM_V);
    is_idl = (m_win == IDL_V);
    for (int i = 0; i < 2; i++) begin
      m_strobe[i] = 0;
      bnd = ((t - m_align[i]) % int'(W)) == 0;
      case (m_st[i])
        0: if (is_com) begin
          m_align[i] = t; m_coms[i] = 1; m_gap[i] = 0;
          m_st[i] = (LC == 1) ? 2 : 1;
        end
        1: if (bnd) begin
          if (is_com) begin
            m_coms[i]++;
            if (m_coms[i] == LC) begin m_st[i] = 2; m_gap[i] = 0; end
          end else begin
            m_coms[i] = 0; m_st[i] = 0;
          end
        end
        default: if (bnd) begin
          if (is_com || is_idl) m_gap[i] = 0; else m_gap[i]++;
          if (glim[i] > 0 && m_gap[i] == glim[i]) begin
            m_st[i] = 0; m_valid[i] = 0;
          end else begin
            m_dout[i] = m_win; m_strobe[i] = 1; m_valid[i] = !(is_com || is_idl);
          end
        end
      endcase
    end
  endfunction

  function automatic logic [10:0] exp_of(input int i);
    return {m_st[i] == 2, m_valid[i], m_strobe[i], m_dout[i]};
  endfunction

  // One serial bit; records any divergence from the model for the caller.
  task automatic step(input bit b);
    bus0.data_in = b;
    bus1.data_in = b;
    @(posedge clk_32f);
    model_edge(b);
    #1;
    if (obs0 !== exp_of(0) || obs1 !== exp_of(1)) begin
      if (lockstep_err == 0)
        first_msg = $sformatf("edge=%0d dut0=%h want0=%h dut1=%h want1=%h",
                              t, obs0, exp_of(0), obs1, exp_of(1));
      lockstep_err++;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) step(v[k]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 7, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    lockstep_err = 0;
  endtask

  task automatic test_reset();
    bus0.data_in = 1'b0;
    bus1.data_in = 1'b0;
    #3 reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (obs0 !== 11'h000 || obs1 !== 11'h000) begin
      failed++;
      $display("FAIL reset_async dut0=%h dut1=%h want 000", obs0, obs1);
    end
    @(posedge clk_32f);
    #1;
    tests++;
    if (obs0 !== 11'h000 || obs1 !== 11'h000) begin
      failed++;
      $display("FAIL reset_held dut0=%h dut1=%h want 000", obs0, obs1);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle_zero();
    bit seen_act, seen_stb;
    do_reset();
    seen_act = 0; seen_stb = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b0);
      seen_act |= bus0.active | bus1.active;
      seen_stb |= bus0.word_strobe | bus1.word_strobe;
    end
    tests++;
    if (seen_act !== 1'b0) begin failed++; $display("FAIL idle_active got %0b want 0", seen_act); end
    tests++;
    if (seen_stb !== 1'b0) begin failed++; $display("FAIL idle_strobe got %0b want 0", seen_stb); end
    tests++;
    if (bus0.data_out !== 8'h00) begin failed++; $display("FAIL idle_data got %h want 00", bus0.data_out); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL idle_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_lock_idle();
    do_reset();
    send_bits(3'($urandom_range(0, 7)), 2, 0);
    for (int k = 0; k < 3; k++) send_byte(COM_V);
    send_bits(COM_V, 7, 1);
    tests++;
    if (bus0.active !== 1'b0) begin failed++; $display("FAIL lock_early active got %0b want 0", bus0.active); end
    send_bits(COM_V, 0, 0);
    tests++;
    if (bus0.active !== 1'b1 || bus0.word_strobe !== 1'b0) begin
      failed++; $display("FAIL lock_edge active/strobe got %0b%0b want 10", bus0.active, bus0.word_strobe);
    end
    send_bits(IDL_V, 7, 1);
    tests++;
    if (bus0.word_strobe !== 1'b0) begin failed++; $display("FAIL lock_strobe_early got %0b want 0", bus0.word_strobe); end
    send_bits(IDL_V, 0, 0);
    tests++;
    if ({bus0.word_strobe, bus0.valid_out, bus0.data_out} !== {1'b1, 1'b0, 8'h7C}) begin
      failed++; $display("FAIL lock_first_word got stb=%0b val=%0b data=%h want 1 0 7c",
                         bus0.word_strobe, bus0.valid_out, bus0.data_out);
    end
    step(1'b1);
    tests++;
    if (bus0.word_strobe !== 1'b0) begin failed++; $display("FAIL lock_strobe_width got %0b want 0", bus0.word_strobe); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL lock_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_data_words();
    logic [7:0] words[2] = '{8'hA5, 8'h3C};
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(COM_V);
    for (int w = 0; w < 2; w++) begin
      send_bits(words[w], 7, 1);
      send_bits(words[w], 0, 0);
      tests++;
      if ({bus0.word_strobe, bus0.valid_out, bus0.data_out} !== {1'b1, 1'b1, words[w]}) begin
        failed++; $display("FAIL data_word%0d got stb=%0b val=%0b data=%h want 1 1 %h",
                           w, bus0.word_strobe, bus0.valid_out, bus0.data_out, words[w]);
      end
    end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL data_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_relock();
    do_reset();
    for (int k = 0; k < 3; k++) send_byte(COM_V);
    send_byte(8'h55);
    tests++;
    if (bus0.active !== 1'b0) begin failed++; $display("FAIL relock_break active got %0b want 0", bus0.active); end
    for (int k = 0; k < 3; k++) send_byte(COM_V);
    send_bits(COM_V, 7, 1);
    tests++;
    if (bus0.active !== 1'b0) begin failed++; $display("FAIL relock_early active got %0b want 0", bus0.active); end
    send_bits(COM_V, 0, 0);
    tests++;
    if (bus0.active !== 1'b1) begin failed++; $display("FAIL relock_lock active got %0b want 1", bus0.active); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL relock_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_gap_timeout();
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(COM_V);
    send_byte(8'h11);
    send_byte(8'h22);
    tests++;
    if ({bus1.active, bus1.valid_out, bus1.data_out} !== {1'b1, 1'b1, 8'h22}) begin
      failed++; $display("FAIL gap_before got act=%0b val=%0b data=%h want 1 1 22",
                         bus1.active, bus1.valid_out, bus1.data_out);
    end
    send_byte(8'h33);
    tests++;
    if (obs1 !== {1'b0, 1'b0, 1'b0, 8'h22}) begin
      failed++; $display("FAIL gap_drop dut1 got %h want 022", obs1);
    end
    tests++;
    if (obs0 !== {1'b1, 1'b1, 1'b1, 8'h33}) begin
      failed++; $display("FAIL gap_nolimit dut0 got %h want 733", obs0);
    end
    for (int k = 0; k < 3; k++) send_byte(COM_V);
    send_bits(COM_V, 7, 1);
    tests++;
    if (bus1.active !== 1'b0) begin failed++; $display("FAIL gap_relock_early active got %0b want 0", bus1.active); end
    send_bits(COM_V, 0, 0);
    tests++;
    if (bus1.active !== 1'b1) begin failed++; $display("FAIL gap_relock active got %0b want 1", bus1.active); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL gap_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(COM_V);
    send_byte(8'h96);
    send_bits(8'hA5, 7, 4);
    #2 reset = 1'b0;
    model_reset();
    #1;
    tests++;
    if (obs0 !== 11'h000 || obs1 !== 11'h000) begin
      failed++; $display("FAIL midreset_async dut0=%h dut1=%h want 000", obs0, obs1);
    end
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1 reset = 1'b1;
    lockstep_err = 0;
    for (int k = 0; k < 3; k++) send_byte(COM_V);
    send_bits(COM_V, 7, 1);
    tests++;
    if (bus0.active !== 1'b0) begin failed++; $display("FAIL midreset_early active got %0b want 0", bus0.active); end
    send_bits(COM_V, 0, 0);
    tests++;
    if (bus0.active !== 1'b1) begin failed++; $display("FAIL midreset_relock active got %0b want 1", bus0.active); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL midreset_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  task automatic test_random_stream();
    bit         ever_active;
    logic [7:0] v;
    int         r;
    do_reset();
    ever_active = 0;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      send_bits(8'($urandom), int'($urandom_range(0, 2)), 0);
      if (r < 45)      v = COM_V;
      else if (r < 60) v = IDL_V;
      else             v = 8'($urandom);
      send_byte(v);
      ever_active |= bus0.active;
    end
    tests++;
    if (ever_active !== 1'b1) begin failed++; $display("FAIL random_lock got %0b want 1", ever_active); end
    tests++;
    if (lockstep_err != 0) begin failed++; $display("FAIL random_model errors=%0d want 0: %s", lockstep_err, first_msg); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_zero();
    test_lock_idle();
    test_data_words();
    test_relock();
    test_gap_timeout();
    test_reset_mid_word();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
